dual_port_ram: RTL and testbench
================================

DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, address width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter READ_LATENCY, default 3, cycles from read acceptance to rvalid; legal range >=1.
REQ-004 SHALL have parameter WRITE_LATENCY, default 3, cycles from write acceptance to array visibility; legal range >=1.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports a_en / b_en, input, 1, request strobe for port A / B, one request per cycle per port.
REQ-008 SHALL have ports a_wr / b_wr, input, 1, 1 = write, 0 = read; sampled only when the matching en is 1.
REQ-009 SHALL have ports a_addr / b_addr, input, ADDR_WIDTH, word address.
REQ-010 SHALL have ports a_wdata / b_wdata, input, DATA_WIDTH, write data.
REQ-011 SHALL have ports a_rdata / b_rdata, output, DATA_WIDTH, read data, registered.
REQ-012 SHALL have ports a_rvalid / b_rvalid, output, 1, single-cycle qualifier for rdata.

Function
REQ-013 A request SHALL be accepted in every cycle with en=1; no backpressure, no ready signal.
REQ-014 Read accepted at edge T SHALL sample the array at T; rdata/rvalid SHALL assert exactly at edge T+READ_LATENCY for one cycle.
REQ-015 Write accepted at edge T SHALL update the array at edge T+WRITE_LATENCY-1; reads accepted at or after edge T+WRITE_LATENCY SHALL return the new data.
REQ-016 Reads accepted before the write commits SHALL return the old array value (no forwarding from the write pipeline).
REQ-017 Read and write committing on the same address in the same cycle SHALL be read-before-write: the read returns the old value.
REQ-018 Writes from A and B committing to the same address in the same cycle SHALL resolve with port A winning; B's data is dropped.
REQ-019 Back-to-back requests on one port SHALL be fully pipelined: N consecutive reads give N consecutive rvalid cycles, in order.
REQ-020 When no read completes in a cycle, rvalid SHALL be 0 and rdata SHALL hold its last value.
REQ-021 Write requests SHALL never assert rvalid.
REQ-022 Addresses SHALL index modulo depth; no out-of-range condition exists.

Reset
REQ-023 rst=1 SHALL asynchronously clear all array words, all read/write pipeline stages, rdata (0) and rvalid (0).
REQ-024 Requests in flight when rst asserts SHALL be discarded: no pending write commits, no pending rvalid appears after release.
REQ-025 Requests presented while rst=1 SHALL be ignored; the first request is accepted at the first rising edge with rst=0.

Structure
REQ-026 DATA_WIDTH, ADDR_WIDTH, READ_LATENCY, WRITE_LATENCY defaults and TIME_PERIOD=10 SHALL live in dual_port_pkg and be imported by RTL and bench.
REQ-027 The latency pipelines SHALL be one reusable sub-module dual_port_delay_line (parameters WIDTH, DEPTH; valid + payload shift register, async reset), instantiated once per port per direction.
REQ-028 The array SHALL be a register file, with no vendor RAM primitive, so reset clearing is legal.

Verification
REQ-029 After reset, A read addr 5 -> a_rvalid=1 with a_rdata=0x00 exactly 3 cycles later.
REQ-030 A write addr 2 = 0xA5 at T0, B read addr 2 at T0+1 and at T0+3 -> first returns 0x00, second returns 0xA5.
REQ-031 A write addr 7 = 0x11 and B write addr 7 = 0x22 in the same cycle, then A read addr 7 -> returns 0x11.
REQ-032 A reads addrs 0..7 on 8 consecutive cycles after filling word i = i*3 -> 8 consecutive rvalid cycles returning 0,3,6,...,21 in order.
REQ-033 A write addr 4 = 0x5A, rst pulsed 1 cycle later, then read addr 4 -> returns 0x00; no rvalid appears during or after reset without a new read.
REQ-034 Random mixed A/B traffic for 10k cycles against a reference model implementing REQ-014..REQ-018 -> zero mismatches.

Source files
------------

// File: rtl/dual_port_pkg.sv
// Shared defaults for the dual-port RAM, its latency pipelines and its bench.
package dual_port_pkg;

  localparam int unsigned DP_DATA_WIDTH    = 8;
  localparam int unsigned DP_ADDR_WIDTH    = 3;
  localparam int unsigned DP_READ_LATENCY  = 3;
  localparam int unsigned DP_WRITE_LATENCY = 3;
  localparam int unsigned DP_TIME_PERIOD   = 10;

endpackage : dual_port_pkg

// File: rtl/dual_port_delay_line.sv
// Valid + payload shift register with asynchronous clear.
// DEPTH = 0 degenerates to a wire so a latency-1 write path needs no stage.
module dual_port_delay_line
  import dual_port_pkg::*;
#(
  parameter int unsigned WIDTH = DP_DATA_WIDTH,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  if (DEPTH == 0) begin : g_bypass
    assign valid_o = valid_i;
    assign data_o  = data_i;
  end else begin : g_pipe
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];

    always_comb begin
      valid_d[0] = valid_i;
      data_d[0]  = data_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          data_q[i] <= '0;
        end
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];
  end

endmodule : dual_port_delay_line

// File: rtl/dual_port_ram.sv
// Two-port register-file RAM with fixed read and write latencies.
// Reads sample the array at acceptance; writes commit WRITE_LATENCY-1 edges later, A over B.
module dual_port_ram
  import dual_port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DP_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH    = DP_ADDR_WIDTH,
  parameter int unsigned READ_LATENCY  = DP_READ_LATENCY,
  parameter int unsigned WRITE_LATENCY = DP_WRITE_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_en,
  input  logic                  a_wr,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_en,
  input  logic                  b_wr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_rvalid
);

  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam int unsigned WR_W      = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned WR_STAGES = WRITE_LATENCY - 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  a_rd_v,  b_rd_v;
  logic [DATA_WIDTH-1:0] a_rd_data, b_rd_data;
  logic                  a_cm_v,  b_cm_v;
  logic [WR_W-1:0]       a_cm,    b_cm;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic                  a_rvalid_q, b_rvalid_q;

  // Read data is captured at acceptance, so later commits cannot leak into it.
  dual_port_delay_line #(.WIDTH(DATA_WIDTH), .DEPTH(READ_LATENCY)) u_a_rd (
    .clk(clk), .rst(rst), .valid_i(a_en & ~a_wr), .data_i(mem_q[a_addr]),
    .valid_o(a_rd_v), .data_o(a_rd_data)
  );

  dual_port_delay_line #(.WIDTH(DATA_WIDTH), .DEPTH(READ_LATENCY)) u_b_rd (
    .clk(clk), .rst(rst), .valid_i(b_en & ~b_wr), .data_i(mem_q[b_addr]),
    .valid_o(b_rd_v), .data_o(b_rd_data)
  );

  dual_port_delay_line #(.WIDTH(WR_W), .DEPTH(WR_STAGES)) u_a_wr (
    .clk(clk), .rst(rst), .valid_i(a_en & a_wr), .data_i({a_addr, a_wdata}),
    .valid_o(a_cm_v), .data_o(a_cm)
  );

  dual_port_delay_line #(.WIDTH(WR_W), .DEPTH(WR_STAGES)) u_b_wr (
    .clk(clk), .rst(rst), .valid_i(b_en & b_wr), .data_i({b_addr, b_wdata}),
    .valid_o(b_cm_v), .data_o(b_cm)
  );

  // Port A is written last so it overrides B on an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (b_cm_v) mem_q[b_cm[DATA_WIDTH +: ADDR_WIDTH]] <= b_cm[DATA_WIDTH-1:0];
      if (a_cm_v) mem_q[a_cm[DATA_WIDTH +: ADDR_WIDTH]] <= a_cm[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (a_rd_v) a_rdata_d = a_rd_data;
    if (b_rd_v) b_rdata_d = b_rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      a_rvalid_q <= a_rd_v;
      b_rvalid_q <= b_rd_v;
    end
  end

  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;

endmodule : dual_port_ram

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: directed scenarios plus random A/B traffic against
// a cycle-stamped array model of the read/write timing rules.
module tb_dual_port_ram;
  import dual_port_pkg::*;

  localparam int unsigned DW    = DP_DATA_WIDTH;
  localparam int unsigned AW    = DP_ADDR_WIDTH;
  localparam int unsigned RL    = DP_READ_LATENCY;
  localparam int unsigned WL    = DP_WRITE_LATENCY;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_en, a_wr, b_en, b_wr;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic          a_rvalid, b_rvalid;

  dual_port_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_en(b_en), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_rvalid(b_rvalid)
  );

  always #(DP_TIME_PERIOD / 2) clk = ~clk;

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } rd_t;

  typedef struct {
    int unsigned   due;
    logic          port_b;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic [DW-1:0] ref_mem [DEPTH];
  rd_t           rq_a[$], rq_b[$];
  wr_t           wq[$];
  logic          exp_a_rvalid, exp_b_rvalid;
  logic [DW-1:0] exp_a_rdata, exp_b_rdata;
  int unsigned   cyc;
  int            checks, errors;

  logic [DW-1:0] got_a[$], got_b[$];
  int unsigned   got_a_cyc[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] qget(input logic [DW-1:0] q[$], input int idx);
    return (idx < q.size()) ? q[idx] : 'x;
  endfunction

  task automatic model_reset();
    foreach (ref_mem[i]) ref_mem[i] = '0;
    rq_a.delete(); rq_b.delete(); wq.delete();
    exp_a_rvalid = 1'b0; exp_b_rvalid = 1'b0;
    exp_a_rdata  = '0;   exp_b_rdata  = '0;
  endtask

  // One accepted edge: reads see the array before this edge's commits; B commits before A.
  task automatic model_edge();
    cyc++;
    if (a_en && !a_wr) rq_a.push_back('{cyc + RL, ref_mem[a_addr]});
    if (b_en && !b_wr) rq_b.push_back('{cyc + RL, ref_mem[b_addr]});
    if (a_en && a_wr)  wq.push_back('{cyc + WL - 1, 1'b0, a_addr, a_wdata});
    if (b_en && b_wr)  wq.push_back('{cyc + WL - 1, 1'b1, b_addr, b_wdata});
    for (int p = 1; p >= 0; p--) begin
      foreach (wq[i]) begin
        if (wq[i].due == cyc && wq[i].port_b == (p == 1)) ref_mem[wq[i].addr] = wq[i].data;
      end
    end
    while (wq.size() > 0 && wq[0].due <= cyc) void'(wq.pop_front());
    exp_a_rvalid = 1'b0;
    exp_b_rvalid = 1'b0;
    if (rq_a.size() > 0 && rq_a[0].due == cyc) begin
      exp_a_rvalid = 1'b1;
      exp_a_rdata  = rq_a[0].data;
      void'(rq_a.pop_front());
    end
    if (rq_b.size() > 0 && rq_b[0].due == cyc) begin
      exp_b_rvalid = 1'b1;
      exp_b_rdata  = rq_b[0].data;
      void'(rq_b.pop_front());
    end
  endtask

  task automatic check_outputs();
    chk("a_rvalid", 32'(a_rvalid), 32'(exp_a_rvalid));
    chk("a_rdata",  32'(a_rdata),  32'(exp_a_rdata));
    chk("b_rvalid", 32'(b_rvalid), 32'(exp_b_rvalid));
    chk("b_rdata",  32'(b_rdata),  32'(exp_b_rdata));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    if (a_rvalid) begin
      got_a.push_back(a_rdata);
      got_a_cyc.push_back(cyc);
    end
    if (b_rvalid) got_b.push_back(b_rdata);
  endtask

  task automatic clear_got();
    got_a.delete(); got_a_cyc.delete(); got_b.delete();
  endtask

  task automatic idle_all();
    a_en = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
    b_en = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic req_a(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    a_en = 1'b1; a_wr = wr; a_addr = addr; a_wdata = data;
  endtask

  task automatic req_b(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    b_en = 1'b1; b_wr = wr; b_addr = addr; b_wdata = data;
  endtask

  task automatic rand_reqs();
    a_en = 1'($urandom); a_wr = 1'($urandom); a_addr = AW'($urandom); a_wdata = DW'($urandom);
    b_en = 1'($urandom); b_wr = 1'($urandom); b_addr = AW'($urandom); b_wdata = DW'($urandom);
  endtask

  // Asserted mid-cycle; requests driven meanwhile must be ignored.
  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    rand_reqs();
    repeat (n) begin
      @(posedge clk);
      cyc++;
      #1;
      chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
      chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
      chk("rst_a_rdata",  32'(a_rdata),  32'd0);
      chk("rst_b_rdata",  32'(b_rdata),  32'd0);
    end
    rst = 1'b0;
    idle_all();
  endtask

  int unsigned t0;

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    idle_all();
    do_reset(2);

    // Read of a cleared word after reset
    clear_got();
    req_a(1'b0, AW'(5), '0);
    step();
    t0 = cyc;
    idle_all();
    repeat (RL) step();
    chk("r029_count", 32'(got_a.size()), 32'd1);
    chk("r029_data",  32'(qget(got_a, 0)), 32'h00);
    chk("r029_lat",   (got_a_cyc.size() > 0) ? got_a_cyc[0] - t0 : 32'hFFFF_FFFF, 32'(RL));

    // Read before commit sees old data, read at T0+3 sees new data
    clear_got();
    req_a(1'b1, AW'(2), 8'hA5);
    step();
    idle_all();
    req_b(1'b0, AW'(2), '0);
    step();
    idle_all();
    step();
    req_b(1'b0, AW'(2), '0);
    step();
    idle_all();
    repeat (RL + 1) step();
    chk("r030_count", 32'(got_b.size()), 32'd2);
    chk("r030_old",   32'(qget(got_b, 0)), 32'h00);
    chk("r030_new",   32'(qget(got_b, 1)), 32'hA5);

    // Same-cycle A/B write collision: A wins
    clear_got();
    req_a(1'b1, AW'(7), 8'h11);
    req_b(1'b1, AW'(7), 8'h22);
    step();
    idle_all();
    repeat (WL) step();
    req_a(1'b0, AW'(7), '0);
    step();
    idle_all();
    repeat (RL) step();
    chk("r031_count", 32'(got_a.size()), 32'd1);
    chk("r031_data",  32'(qget(got_a, 0)), 32'h11);

    // Fill word i = i*3, then 8 back-to-back reads
    for (int i = 0; i < 8; i++) begin
      req_a(1'b1, AW'(i), DW'(i * 3));
      step();
    end
    idle_all();
    repeat (WL) step();
    clear_got();
    for (int i = 0; i < 8; i++) begin
      req_a(1'b0, AW'(i), '0);
      step();
    end
    idle_all();
    repeat (RL) step();
    chk("r032_count", 32'(got_a.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("r032_data", 32'(qget(got_a, i)), 32'(i * 3));
    chk("r032_span", (got_a_cyc.size() == 8) ? got_a_cyc[7] - got_a_cyc[0] : 32'hFFFF_FFFF, 32'd7);

    // Reset discards an in-flight write and pending reads
    clear_got();
    req_a(1'b1, AW'(4), 8'h5A);
    step();
    req_a(1'b0, AW'(3), '0);
    step();
    idle_all();
    do_reset(1);
    repeat (RL + 2) step();
    chk("r033_no_rvalid", 32'(got_a.size() + got_b.size()), 32'd0);
    req_a(1'b0, AW'(4), '0);
    step();
    idle_all();
    repeat (RL) step();
    chk("r033_count", 32'(got_a.size()), 32'd1);
    chk("r033_data",  32'(qget(got_a, 0)), 32'h00);

    // Random mixed traffic with rare resets
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 2999) == 0) do_reset(2);
      rand_reqs();
      step();
    end
    idle_all();
    repeat (RL + 2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dual_port_ram
